// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences MEM-stage loads and stores onto an SRAM-like req/addr_ok/data_ok
// bus. While a transaction is outstanding it stalls the pipeline. It aligns
// and extends load data, and it flags misaligned accesses.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   mem_*_i           request from the MEM stage (valid, we, size, signed,
//                     addr, wdata)
//   flush_i           pipeline flush; cancels a start or an in-flight access
//   stall_o           hold MEM and earlier stages
//   ld_valid_o        one-cycle completion pulse (loads and stores)
//   ld_data_o         aligned/extended load result (0 for stores)
//   ale_o             misaligned-address exception (combinational)
//   bus_*_o           registered bus request (req, wr, wstrb, addr, wdata)
//   bus_*_i           bus handshake and read data
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_signed_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ld_valid_o,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic                  ale_o,
    output logic                  bus_req_o,
    output logic                  bus_wr_o,
    output logic [3:0]            bus_wstrb_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_addr_ok_i,
    input  logic                  bus_data_ok_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic        r_cancel;
    logic [1:0]  r_size;
    logic        r_signed;

    logic                  w_misaligned;
    logic                  w_idle_ok;
    logic                  w_start;
    logic                  w_drop;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_misaligned = ((mem_size_i == 2'b01) & mem_addr_i[0]) |
                          (mem_size_i[1] & (|mem_addr_i[1:0]));
    assign w_idle_ok    = mem_valid_i & (r_state == S_IDLE) & ~flush_i;
    assign ale_o        = w_idle_ok & w_misaligned;
    assign w_start      = w_idle_ok & ~w_misaligned;
    assign stall_o      = (r_state == S_REQ) | (r_state == S_WAIT) | w_start;

    // A flush arriving in the same cycle as data_ok also discards the data,
    // so the flushed instruction can never retire.
    assign w_drop = r_cancel | flush_i;

    // Store lane steering: data is replicated across lanes, strobes select.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = mem_wdata_i;
        case (mem_size_i)
            2'b00: begin
                w_wstrb = 4'b0001 << mem_addr_i[1:0];
                w_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << mem_addr_i[1:0];
                w_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: w_wstrb = 4'b1111;
        endcase
        if (!mem_we_i) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load alignment uses the latched address held on bus_addr_o.
    assign w_shifted = bus_rdata_i >> {bus_addr_o[1:0], 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_ld_data = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_ld_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ld_data = bus_rdata_i;
        endcase
        if (bus_wr_o) begin
            w_ld_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cancel    <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_wr_o    <= 1'b0;
            bus_wstrb_o <= 4'b0000;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            ld_valid_o  <= 1'b0;
            ld_data_o   <= '0;
        end else begin
            ld_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        bus_req_o   <= 1'b1;
                        bus_wr_o    <= mem_we_i;
                        bus_wstrb_o <= w_wstrb;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= w_wdata;
                        r_size      <= mem_size_i;
                        r_signed    <= mem_signed_i;
                        r_cancel    <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The request cannot be withdrawn; a flush only marks it.
                    r_cancel <= r_cancel | flush_i;
                    if (bus_addr_ok_i) begin
                        bus_req_o <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_data_ok_i) begin
                        r_cancel <= 1'b0;
                        if (w_drop) begin
                            r_state <= S_IDLE;
                        end else begin
                            ld_data_o  <= w_ld_data;
                            ld_valid_o <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end else begin
                        r_cancel <= r_cancel | flush_i;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_we_i, mem_signed_i, flush_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        stall_o, ld_valid_o, ale_o;
    logic [31:0] ld_data_o;
    logic        bus_req_o, bus_wr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_addr_ok_i, bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_signed_i(mem_signed_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .stall_o(stall_o), .ld_valid_o(ld_valid_o),
        .ld_data_o(ld_data_o), .ale_o(ale_o), .bus_req_o(bus_req_o),
        .bus_wr_o(bus_wr_o), .bus_wstrb_o(bus_wstrb_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_addr_ok_i(bus_addr_ok_i),
        .bus_data_ok_i(bus_data_ok_i), .bus_rdata_i(bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, bus_req_o},   32'd0);
        check({tag, "_wr"},    {31'd0, bus_wr_o},    32'd0);
        check({tag, "_wstrb"}, {28'd0, bus_wstrb_o}, 32'd0);
        check({tag, "_addr"},  bus_addr_o,           32'd0);
        check({tag, "_wdata"}, bus_wdata_o,          32'd0);
        check({tag, "_ldv"},   {31'd0, ld_valid_o},  32'd0);
        check({tag, "_ldd"},   ld_data_o,            32'd0);
    endtask

    // Runs one access starting just after a negedge. The bench plays the bus
    // slave: addr_ok after 'ad' extra REQ cycles, data_ok 'dd' cycles later.
    // 'fl' is the index of the REQ/WAIT cycle carrying a flush, -1 for none.
    task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic we,
                          input logic sg, input logic [31:0] wd, input logic [31:0] rd,
                          input int ad, input int dd, input int fl);
        logic        mis, canc;
        int          nb, off, total, nst;
        logic [3:0]  es;
        logic [31:0] ew, sh, mask, el;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off  = int'(a[1:0]);
        mis  = (off % nb) != 0;
        // Reference: lanes off..off+nb-1 enabled, each lane carries byte (i mod nb).
        es = 4'd0;
        ew = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (we && i >= off && i < off + nb) es[i] = 1'b1;
            ew[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        sh   = rd >> (8 * off);
        mask = 32'((64'd1 << (8 * nb)) - 64'd1);
        el   = sh & mask;
        if (sg && nb < 4 && sh[8*nb-1]) el = el | ~mask;
        if (we) el = 32'd0;

        mem_valid_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_signed_i = sg;
        mem_addr_i = a; mem_wdata_i = wd; flush_i = 1'b0;
        #1;
        check("ale", {31'd0, ale_o}, {31'd0, mis});
        check("stall_start", {31'd0, stall_o}, {31'd0, !mis});
        if (mis) begin
            @(posedge clk); @(negedge clk);
            mem_valid_i = 1'b0;
            #1;
            check("ale_no_req", {31'd0, bus_req_o}, 32'd0);
            check("ale_no_stall", {31'd0, stall_o}, 32'd0);
            $display("[TB] access a=%h sz=%0d we=%0d -> misaligned", a, sz, we);
            return;
        end
        nst   = 1;
        total = ad + 1 + dd;
        canc  = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int c = 0; c < total; c++) begin
            if (c <= ad) begin
                check("req", {31'd0, bus_req_o}, 32'd1);
                check("addr", bus_addr_o, a);
                check("wr", {31'd0, bus_wr_o}, {31'd0, we});
                check("wstrb", {28'd0, bus_wstrb_o}, {28'd0, es});
                if (we) check("wdata", bus_wdata_o, ew);
            end else begin
                check("req_low_wait", {31'd0, bus_req_o}, 32'd0);
            end
            check("ldv_early", {31'd0, ld_valid_o}, 32'd0);
            if (stall_o) nst++;
            bus_addr_ok_i = (c == ad);
            bus_data_ok_i = (c == total - 1);
            bus_rdata_i   = (c == total - 1) ? rd : $urandom;
            flush_i       = (c == fl);
            if (c == fl) begin
                canc = 1'b1;
                mem_valid_i = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; flush_i = 1'b0;
        check("stall_cycles", 32'(nst), 32'(1 + total));
        if (canc) begin
            mem_valid_i = 1'b0;
            #1;
            check("cancel_no_ldv", {31'd0, ld_valid_o}, 32'd0);
            check("cancel_stall_drop", {31'd0, stall_o}, 32'd0);
        end else begin
            #1;
            check("ldv", {31'd0, ld_valid_o}, 32'd1);
            check("ld_data", ld_data_o, el);
            check("done_stall", {31'd0, stall_o}, 32'd0);
            mem_valid_i = 1'b0;
            @(posedge clk); @(negedge clk);
            check("ldv_one_cycle", {31'd0, ld_valid_o}, 32'd0);
        end
        $display("[TB] access a=%h sz=%0d we=%0d sg=%0d ad=%0d dd=%0d flush=%0d ld=%h exp=%h",
                 a, sz, we, sg, ad, dd, fl, ld_data_o, el);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'd0; mem_signed_i = 1'b0;
        mem_addr_i = 32'd0; mem_wdata_i = 32'd0; flush_i = 1'b0;
        bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = 32'd0;
        @(negedge clk); @(negedge clk);
        check_all_zero("reset");
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed steps
        access(32'h0000_1003, 2'd0, 1'b0, 1'b1, 32'd0, 32'h80FF_0000, 0, 1, -1);
        access(32'h0000_2002, 2'd1, 1'b1, 1'b0, 32'h0000_BEEF, 32'd0, 0, 1, -1);
        access(32'h0000_3001, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 0, 1, -1);
        access(32'h0000_4000, 2'd2, 1'b0, 1'b0, 32'd0, 32'hCAFE_F00D, 3, 2, -1);
        access(32'h0000_5000, 2'd2, 1'b0, 1'b0, 32'd0, 32'h1234_5678, 0, 2, 1);
        access(32'h0000_6000, 2'd1, 1'b1, 1'b0, 32'h1111_2222, 32'd0, 2, 1, 0);

        // Flush in IDLE blocks the start and masks ale
        mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2; mem_addr_i = 32'h3001;
        flush_i = 1'b1;
        #1;
        check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
        check("flush_idle_ale", {31'd0, ale_o}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("flush_idle_no_req", {31'd0, bus_req_o}, 32'd0);
        mem_valid_i = 1'b0; flush_i = 1'b0;
        $display("[TB] flush in IDLE blocked start");

        // Async reset while in WAIT
        mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h7000;
        mem_wdata_i = 32'hA5A5_5A5A;
        @(posedge clk); @(negedge clk);
        bus_addr_ok_i = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_addr_ok_i = 1'b0; mem_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        check("async_rst_stall", {31'd0, stall_o}, 32'd0);
        $display("[TB] async reset in WAIT");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(32'h0000_8002, 2'd1, 1'b0, 1'b1, 32'd0, 32'h9ABC_0000, 0, 1, -1);

        // Randomized accesses against the reference model
        for (int n = 0; n < 60; n++) begin
            int ad, dd, fl;
            ad = $urandom_range(0, 3);
            dd = $urandom_range(1, 3);
            fl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ad + dd) : -1;
            access($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, ad, dd, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory loads and stores issued by the MEM pipeline stage onto an SRAM-like request/response bus (req/addr_ok/data_ok).
- Holds the pipeline with a stall while a transaction is outstanding.
- Aligns and extends load data, and flags misaligned accesses.
- Sits between the MEM stage and the data-side bus interface.

Parameters:
ADDR_WIDTH, 32, width of memory address.
DATA_WIDTH, 32, width of bus data (fixed 4 byte lanes; only 32 supported).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
mem_valid_i  in  1  MEM stage holds a memory instruction
mem_we_i  in  1  1=store, 0=load
mem_size_i  in  2  00 byte, 01 half, 10/11 word
mem_signed_i  in  1  load sign-extends when 1
mem_addr_i  in  ADDR_WIDTH  byte address
mem_wdata_i  in  DATA_WIDTH  store data (LSB-justified)
flush_i  in  1  pipeline flush
stall_o  out  1  hold MEM and earlier stages
ld_valid_o  out  1  one-cycle pulse, load/store completed
ld_data_o  out  DATA_WIDTH  aligned, extended load result
ale_o  out  1  misaligned-address exception
bus_req_o  out  1  bus request
bus_wr_o  out  1  bus write
bus_wstrb_o  out  4  byte enables
bus_addr_o  out  ADDR_WIDTH  bus address
bus_wdata_o  out  DATA_WIDTH  lane-replicated store data
bus_addr_ok_i  in  1  request accepted
bus_data_ok_i  in  1  response/ack returned
bus_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. A cancel flag is set by flush in REQ/WAIT.
- Reset (async): state=IDLE, cancel=0. All registered outputs are 0: bus_req_o, bus_wr_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, ld_valid_o, ld_data_o. Any outstanding bus transaction is abandoned; the bus slave shares the same reset.
- Alignment check (combinational):
  - ale_o = mem_valid_i & state==IDLE & !flush_i & misaligned.
  - Misaligned means half with addr[0]!=0, or word with addr[1:0]!=0.
  - When ale_o=1: no bus access, stall_o=0.
- IDLE:
  - If mem_valid_i & !flush_i & aligned: latch addr/size/signed/we/wdata, go to REQ.
  - stall_o=1 in this cycle.
- REQ:
  - bus_req_o=1 with the latched request; it is held stable until bus_addr_o accepted (bus_addr_ok_i=1).
  - On addr_ok: go to WAIT. addr_ok and data_ok never arrive in the same cycle.
- WAIT: on bus_data_ok_i:
  - If not cancelled: capture ld_data_o, go to DONE.
  - If cancelled: discard the data, clear cancel, go to IDLE.
- DONE:
  - ld_valid_o=1 for exactly one cycle; stall_o=0, so the pipeline advances.
  - mem_valid_i is ignored in this cycle; next state is IDLE.
- stall_o = (state==REQ) | (state==WAIT) | (IDLE & starting a request).
- Flush:
  - Flush in IDLE blocks the start.
  - Flush in REQ or WAIT sets cancel. The request is still held until addr_ok, because the bus protocol forbids withdrawing it.
  - stall_o stays 1 until a cancelled transaction drains.
  - A cancelled store may still complete on the bus.
- Store lane rules:
  - byte: wstrb = 0001 << addr[1:0], wdata = {4{b}}.
  - half: wstrb = 0011 << addr[1:0], wdata = {2{h}}.
  - word: wstrb = 1111.
  - Loads: wstrb = 0000, bus_wr_o = 0.
- Load rules:
  - shifted = rdata >> (8*addr[1:0]).
  - byte and half are zero- or sign-extended per the latched signed bit; word passes through.
- Store completion also pulses ld_valid_o. ld_data_o is don't-care for stores (value 0).
- Latency with a zero-wait bus (addr_ok in the REQ cycle, data_ok the next cycle): stall_o is high 3 cycles, ld_valid_o in the 4th. Back-to-back accesses have a 1-cycle gap (DONE→IDLE).

Test Plan:
- Load byte signed, addr=0x1003, rdata=0x80FF_0000, zero-wait bus → bus_wstrb=0000; stall 3 cycles; ld_valid pulse; ld_data=0xFFFF_FF80.
- Store half, addr=0x2002, wdata=0x0000_BEEF → bus_wr=1, wstrb=1100, bus_wdata=0xBEEF_BEEF, addr=0x2002; ld_valid pulse on data_ok.
- Load word, addr=0x3001 → ale_o=1 same cycle; bus_req never asserted; stall_o=0.
- Load with addr_ok delayed 3 cycles and data_ok delayed 2 more → bus_req and addr stable throughout; stall high until data_ok; ld_valid exactly 1 cycle.
- Flush in WAIT, then data_ok with rdata=0x1234_5678 → no ld_valid; stall drops after data_ok; state back to IDLE.
- Assert rst while in WAIT → all outputs 0 immediately (async); a next load from IDLE completes correctly.
